// File: rtl/legv8_bus_pkg.sv
// Shared types and helpers for the LEGv8 memory bus arbiter.
//   state_e  : arbiter FSM states (IDLE, ACCESS, DONE)
//   grant_e  : which requester owns the current transaction
//   ADDR_W / DATA_W / INSTR_W : bus address, bus data and instruction widths
//   align_dword : clears the byte-in-doubleword bits of an address
//   select_word : picks the 32-bit instruction half of a 64-bit bus word
package legv8_bus_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_e;

  // The bus only carries doubleword addresses.
  function automatic logic [ADDR_W-1:0] align_dword(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:3], 3'b000};
  endfunction

  // Address bit 2 selects the upper instruction word of the doubleword.
  function automatic logic [INSTR_W-1:0] select_word(input logic [DATA_W-1:0] data,
                                                     input logic              upper);
    logic [INSTR_W-1:0] word;
    if (upper) begin
      word = data[DATA_W-1:INSTR_W];
    end else begin
      word = data[INSTR_W-1:0];
    end
    return word;
  endfunction

endpackage

// File: rtl/legv8_wait_counter.sv
// Loadable down-counter that times the ACCESS phase of a bus transaction.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   load_i       : load MAX_COUNT (takes precedence over dec_i)
//   dec_i        : decrement by one; saturates at zero
//   zero_o       : count is zero (last ACCESS cycle)
module legv8_wait_counter #(
  parameter int MAX_COUNT = 2,
  parameter int CNT_W     = ($clog2(MAX_COUNT + 1) > 0) ? $clog2(MAX_COUNT + 1) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next-count selection: load, decrement or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(MAX_COUNT);
    end else if (dec_i && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/legv8_mem_bus_arbiter.sv
// Shares the single LEGv8 memory bus between the instruction-fetch port and the
// load/store data port. One transaction at a time: IDLE (arbitrate and latch the
// winner) -> ACCESS (WAIT_STATES+1 cycles, bus enabled) -> DONE (one-cycle ack).
// Data wins arbitration unless a waiting fetch has already seen MAX_DATA_STREAK
// consecutive data grants.
// Ports:
//   clock, reset         : rising-edge clock, asynchronous active-high reset
//   if_req/if_addr       : fetch request and byte address (bit 2 selects the word)
//   if_rdata/if_ack      : fetched instruction, valid with the one-cycle ack
//   d_req/d_we/d_addr    : data request, store enable, doubleword address
//   d_wdata              : store data
//   d_rdata/d_ack        : load data, valid with the one-cycle ack
//   mem_addr/mem_en/mem_we : bus address and strobes
//   mem_data             : tri-state bus, driven only during a store ACCESS
module legv8_mem_bus_arbiter
  import legv8_bus_pkg::*;
#(
  parameter int WAIT_STATES     = 2,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic [INSTR_W-1:0] if_rdata,
  output logic               if_ack,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [DATA_W-1:0]  d_wdata,
  output logic [DATA_W-1:0]  d_rdata,
  output logic               d_ack,
  output logic [ADDR_W-1:0]  mem_addr,
  inout  wire  [DATA_W-1:0]  mem_data,
  output logic               mem_en,
  output logic               mem_we
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  state_e              state_q,    state_d;
  grant_e              gnt_q,      gnt_d;
  logic [ADDR_W-1:0]   addr_q,     addr_d;
  logic                we_q,       we_d;
  logic [DATA_W-1:0]   wdata_q,    wdata_d;
  logic                wsel_q,     wsel_d;
  logic [STREAK_W-1:0] streak_q,   streak_d;
  logic [INSTR_W-1:0]  if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q,  d_rdata_d;
  logic                if_ack_q,   if_ack_d;
  logic                d_ack_q,    d_ack_d;
  logic                mem_en_q,   mem_en_d;
  logic                mem_we_q,   mem_we_d;

  logic fetch_starved;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;
  logic addr_lsb_unused;

  // Low address bits carry no information on a doubleword bus.
  assign addr_lsb_unused = ^{if_addr[1:0], d_addr[2:0]};

  // A waiting fetch pre-empts data once the data streak has reached its limit.
  assign fetch_starved = if_req && (streak_q == STREAK_MAX);

  legv8_wait_counter #(
    .MAX_COUNT (WAIT_STATES)
  ) u_wait_counter (
    .clock  (clock),
    .reset  (reset),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .zero_o (cnt_zero)
  );

  // Next-state, arbitration and datapath capture.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wsel_d     = wsel_q;
    streak_d   = streak_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_req && !fetch_starved) begin
          gnt_d    = GNT_D;
          addr_d   = align_dword(d_addr);
          we_d     = d_we;
          wdata_d  = d_wdata;
          wsel_d   = 1'b0;
          // The streak only counts data grants that made a fetch wait.
          if (if_req) begin
            streak_d = streak_q + STREAK_W'(1);
          end else begin
            streak_d = {STREAK_W{1'b0}};
          end
          cnt_load = 1'b1;
          mem_en_d = 1'b1;
          mem_we_d = d_we;
          state_d  = ACCESS;
        end else if (if_req) begin
          gnt_d    = GNT_IF;
          addr_d   = align_dword(if_addr);
          we_d     = 1'b0;
          wsel_d   = if_addr[2];
          streak_d = {STREAK_W{1'b0}};
          cnt_load = 1'b1;
          mem_en_d = 1'b1;
          mem_we_d = 1'b0;
          state_d  = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end

      ACCESS: begin
        if (!cnt_zero) begin
          cnt_dec  = 1'b1;
          mem_en_d = 1'b1;
          mem_we_d = we_q;
          state_d  = ACCESS;
        end else begin
          // Last ACCESS cycle: sample the bus and hand the ack to the winner.
          if (gnt_q == GNT_IF) begin
            if_rdata_d = select_word(mem_data, wsel_q);
            if_ack_d   = 1'b1;
          end else begin
            if (!we_q) begin
              d_rdata_d = mem_data;
            end else begin
              d_rdata_d = d_rdata_q;
            end
            d_ack_d = 1'b1;
          end
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched transaction and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= GNT_IF;
      addr_q     <= {ADDR_W{1'b0}};
      we_q       <= 1'b0;
      wdata_q    <= {DATA_W{1'b0}};
      wsel_q     <= 1'b0;
      streak_q   <= {STREAK_W{1'b0}};
      if_rdata_q <= {INSTR_W{1'b0}};
      d_rdata_q  <= {DATA_W{1'b0}};
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      wsel_q     <= wsel_d;
      streak_q   <= streak_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
    end
  end

  assign if_rdata = if_rdata_q;
  assign if_ack   = if_ack_q;
  assign d_rdata  = d_rdata_q;
  assign d_ack    = d_ack_q;
  assign mem_addr = addr_q;
  assign mem_en   = mem_en_q;
  assign mem_we   = mem_we_q;

  // mem_we_q is high exactly during a store ACCESS, which is when the bus is ours.
  assign mem_data = mem_we_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_legv8_mem_bus_arbiter.sv
// Self-checking bench for legv8_mem_bus_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_legv8_mem_bus_arbiter;

  localparam int WS   = 2;
  localparam int MAXS = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Main DUT (WAIT_STATES=2)
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [63:0] d_wdata;
  logic [63:0] d_rdata;
  logic        d_ack;
  logic [31:0] mem_addr;
  wire  [63:0] mem_data;
  logic        mem_en;
  logic        mem_we;

  // Second DUT (WAIT_STATES=0)
  logic        w0_d_req;
  logic [31:0] w0_d_addr;
  logic [31:0] w0_if_rdata;
  logic        w0_if_ack;
  logic [63:0] w0_d_rdata;
  logic        w0_d_ack;
  logic [31:0] w0_mem_addr;
  wire  [63:0] w0_mem_data;
  logic        w0_mem_en;
  logic        w0_mem_we;

  legv8_mem_bus_arbiter #(.WAIT_STATES(WS), .MAX_DATA_STREAK(MAXS)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_en(mem_en), .mem_we(mem_we)
  );

  legv8_mem_bus_arbiter #(.WAIT_STATES(0), .MAX_DATA_STREAK(MAXS)) dut_w0 (
    .clock(clock), .reset(reset),
    .if_req(1'b0), .if_addr(32'h0), .if_rdata(w0_if_rdata), .if_ack(w0_if_ack),
    .d_req(w0_d_req), .d_we(1'b0), .d_addr(w0_d_addr), .d_wdata(64'h0),
    .d_rdata(w0_d_rdata), .d_ack(w0_d_ack),
    .mem_addr(w0_mem_addr), .mem_data(w0_mem_data), .mem_en(w0_mem_en), .mem_we(w0_mem_we)
  );

  // Memory contents before any store.
  function automatic logic [63:0] init_val(input logic [7:0] idx);
    if (idx == 8'h20) return 64'hAAAA_BBBB_CCCC_DDDD;
    return {24'hC0FFEE, idx, 24'hBEEF00, ~idx};
  endfunction

  // External memory model on the main bus (2 KB, upper address bits alias).
  logic [63:0] bus_mem [256];
  bit          bus_wr  [256];
  logic [63:0] rd_val;
  logic        probe_en;
  logic [63:0] probe_val;

  always @(posedge clock) begin
    if (mem_en && mem_we) begin
      bus_mem[mem_addr[10:3]] <= mem_data;
      bus_wr[mem_addr[10:3]]  <= 1'b1;
    end
  end

  assign rd_val   = bus_wr[mem_addr[10:3]] ? bus_mem[mem_addr[10:3]] : init_val(mem_addr[10:3]);
  assign mem_data = (mem_en && !mem_we) ? rd_val : (probe_en ? probe_val : 64'bz);

  assign w0_mem_data = (w0_mem_en && !w0_mem_we) ? init_val(w0_mem_addr[10:3]) : 64'bz;

  // Reference view of memory, updated at transaction grant.
  logic [63:0] ref_mem [256];
  bit          ref_wr  [256];

  function automatic logic [63:0] ref_read(input logic [7:0] idx);
    return ref_wr[idx] ? ref_mem[idx] : init_val(idx);
  endfunction

  task automatic wait_ack(input bit want_d, input int max_cyc, output int at);
    at = -1;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clock);
      if ((want_d ? d_ack : if_ack) === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({mem_en, mem_we, if_ack, d_ack} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 0000", {mem_en, mem_we, if_ack, d_ack});
    end
    n_cmp++;
    if (mem_addr !== 32'h0) begin
      n_err++; $display("FAIL reset_addr: got %h expected 0", mem_addr);
    end
    n_cmp++;
    if (if_rdata !== 32'h0 || d_rdata !== 64'h0) begin
      n_err++; $display("FAIL reset_rdata: got %h/%h expected 0/0", if_rdata, d_rdata);
    end
    n_cmp++;
    if ({w0_mem_en, w0_mem_we, w0_if_ack, w0_d_ack} !== 4'b0000 || w0_mem_addr !== 32'h0 ||
        w0_if_rdata !== 32'h0 || w0_d_rdata !== 64'h0) begin
      n_err++; $display("FAIL reset_w0: got en%b we%b ack%b%b addr %h rd %h/%h expected all 0",
                        w0_mem_en, w0_mem_we, w0_if_ack, w0_d_ack, w0_mem_addr, w0_if_rdata, w0_d_rdata);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_fetch_only();
    int t0, at;
    logic [31:0] rd;
    if_req = 1'b1; if_addr = 32'h0000_0104; t0 = cyc;
    wait_ack(1'b0, 20, at);
    rd = if_rdata;
    if_req = 1'b0;
    n_cmp++;
    if (at - t0 != 4) begin
      n_err++; $display("FAIL fetch_latency: got %0d expected 4", at - t0);
    end
    n_cmp++;
    if (rd !== 32'hAAAA_BBBB) begin
      n_err++; $display("FAIL fetch_data: got %h expected aaaabbbb", rd);
    end
    @(negedge clock);
    n_cmp++;
    if (if_ack !== 1'b0) begin
      n_err++; $display("FAIL fetch_ack_width: got %b expected 0", if_ack);
    end
  endtask

  task automatic test_store_load();
    int t0, got, we_cycles;
    bit drive_ok;
    logic [31:0] seen_addr;
    logic [63:0] rd;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0040; d_wdata = 64'h0123_4567_89AB_CDEF;
    t0 = cyc; got = -1; we_cycles = 0; drive_ok = 1'b1; rd = 64'h0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (mem_we === 1'b1) begin
        we_cycles++;
        if (mem_data !== 64'h0123_4567_89AB_CDEF || mem_addr !== 32'h40) drive_ok = 1'b0;
      end
      if (d_ack === 1'b1) begin
        got = cyc - t0; rd = d_rdata; break;
      end
    end
    d_req = 1'b0;
    ref_mem[8] = 64'h0123_4567_89AB_CDEF; ref_wr[8] = 1'b1;
    n_cmp++;
    if (we_cycles != 3 || !drive_ok) begin
      n_err++; $display("FAIL store_drive: got %0d cycles ok=%0d expected 3 cycles ok=1", we_cycles, drive_ok);
    end
    n_cmp++;
    if (got != 4 || rd !== 64'h0) begin
      n_err++; $display("FAIL store_ack: got lat %0d rdata %h expected lat 4 rdata 0", got, rd);
    end
    @(negedge clock);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0047; t0 = cyc; got = -1; seen_addr = 32'hFFFF_FFFF;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (mem_en === 1'b1) seen_addr = mem_addr;
      if (d_ack === 1'b1) begin
        got = cyc - t0; rd = d_rdata; break;
      end
    end
    d_req = 1'b0;
    n_cmp++;
    if (seen_addr !== 32'h40) begin
      n_err++; $display("FAIL load_addr: got %h expected 00000040", seen_addr);
    end
    n_cmp++;
    if (got != 4 || rd !== 64'h0123_4567_89AB_CDEF) begin
      n_err++; $display("FAIL load_data: got lat %0d data %h expected lat 4 data 0123456789abcdef", got, rd);
    end
    @(negedge clock);
  endtask

  task automatic test_simultaneous();
    int t0, td, ti;
    logic [63:0] drd, expw;
    logic [31:0] ird;
    if_req = 1'b1; if_addr = 32'h0000_0050;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0100;
    t0 = cyc; td = -1; ti = -1; drd = 64'h0; ird = 32'h0;
    for (int k = 0; k < 30 && (td < 0 || ti < 0); k++) begin
      @(negedge clock);
      if (d_ack === 1'b1) begin td = cyc; drd = d_rdata; d_req = 1'b0; end
      if (if_ack === 1'b1) begin ti = cyc; ird = if_rdata; if_req = 1'b0; end
    end
    if_req = 1'b0; d_req = 1'b0;
    expw = init_val(8'h0A);
    n_cmp++;
    if (td - t0 != 4 || drd !== 64'hAAAA_BBBB_CCCC_DDDD) begin
      n_err++; $display("FAIL simul_data_first: got lat %0d data %h expected lat 4 data aaaabbbbccccdddd", td - t0, drd);
    end
    n_cmp++;
    if (ti - td != 5 || ird !== expw[31:0]) begin
      n_err++; $display("FAIL simul_fetch_next: got gap %0d data %h expected gap 5 data %h", ti - td, ird, expw[31:0]);
    end
    @(negedge clock);
  endtask

  task automatic test_starvation();
    int d_before, d_between, nf, both;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0210;
    if_req = 1'b1; if_addr = 32'h0000_0300;
    d_before = 0; d_between = 0; nf = 0; both = 0;
    for (int k = 0; k < 80 && nf < 2; k++) begin
      @(negedge clock);
      if (d_ack === 1'b1 && if_ack === 1'b1) both++;
      if (d_ack === 1'b1) begin
        if (nf == 0) d_before++; else d_between++;
      end
      if (if_ack === 1'b1) nf++;
    end
    d_req = 1'b0; if_req = 1'b0;
    n_cmp++;
    if (d_before != MAXS || nf < 1 || both != 0) begin
      n_err++; $display("FAIL starve_first: got %0d data acks then %0d fetch acks expected 4 then >=1", d_before, nf);
    end
    n_cmp++;
    if (d_between != MAXS || nf != 2) begin
      n_err++; $display("FAIL starve_streak_clear: got %0d data acks, %0d fetch acks expected 4 and 2", d_between, nf);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_store();
    int t0, at, acks;
    logic [63:0] rd;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0080; d_wdata = 64'hFEED_0000_DEAD_BEEF;
    @(negedge clock);
    n_cmp++;
    if (mem_en !== 1'b1 || mem_data !== 64'hFEED_0000_DEAD_BEEF) begin
      n_err++; $display("FAIL abort_pre_drive: got en %b data %h expected en 1 data feed0000deadbeef", mem_en, mem_data);
    end
    @(negedge clock);
    reset = 1'b1; d_req = 1'b0;
    probe_val = 64'h0112_FFFF_2152_4110; probe_en = 1'b1;
    #1;
    n_cmp++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
      n_err++; $display("FAIL abort_strobes: got en %b we %b expected 0 0", mem_en, mem_we);
    end
    n_cmp++;
    if (mem_data !== 64'h0112_FFFF_2152_4110) begin
      n_err++; $display("FAIL abort_bus_release: got %h expected 0112ffff21524110", mem_data);
    end
    probe_en = 1'b0;
    ref_mem[16] = 64'hFEED_0000_DEAD_BEEF; ref_wr[16] = 1'b1;
    acks = 0;
    repeat (2) begin @(negedge clock); if (d_ack === 1'b1 || if_ack === 1'b1) acks++; end
    reset = 1'b0;
    repeat (6) begin @(negedge clock); if (d_ack === 1'b1 || if_ack === 1'b1) acks++; end
    n_cmp++;
    if (acks != 0) begin
      n_err++; $display("FAIL abort_no_ack: got %0d acks expected 0", acks);
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040; t0 = cyc;
    wait_ack(1'b1, 20, at);
    rd = d_rdata;
    d_req = 1'b0;
    n_cmp++;
    if (at - t0 != 4 || rd !== 64'h0123_4567_89AB_CDEF) begin
      n_err++; $display("FAIL abort_recover_load: got lat %0d data %h expected lat 4 data 0123456789abcdef", at - t0, rd);
    end
    @(negedge clock);
  endtask

  task automatic test_zero_wait();
    int t0, at, en_cycles;
    logic en_at_ack;
    logic [63:0] rd, expv;
    w0_d_req = 1'b1; w0_d_addr = 32'h0000_0048; t0 = cyc; at = -1; en_cycles = 0;
    en_at_ack = 1'b1; rd = 64'h0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (w0_mem_en === 1'b1) en_cycles++;
      if (w0_d_ack === 1'b1) begin
        at = cyc; rd = w0_d_rdata; en_at_ack = w0_mem_en; break;
      end
    end
    w0_d_req = 1'b0;
    expv = init_val(8'h09);
    n_cmp++;
    if (at - t0 != 2 || rd !== expv) begin
      n_err++; $display("FAIL w0_load: got lat %0d data %h expected lat 2 data %h", at - t0, rd, expv);
    end
    n_cmp++;
    if (en_cycles != 1 || en_at_ack !== 1'b0) begin
      n_err++; $display("FAIL w0_bus_release: got %0d en cycles, en at ack %b expected 1 and 0", en_cycles, en_at_ack);
    end
    @(negedge clock);
  endtask

  task automatic test_random(input int n_cycles);
    int free_at, streak, exp_if_at, exp_d_at, en_from, en_to;
    logic [31:0] exp_addr, exp_if_data;
    logic [63:0] exp_d_data, last_load, tmp;
    logic en_exp;
    bit if_drop, d_drop;
    free_at = cyc + 1; streak = 0; exp_if_at = -1; exp_d_at = -1; en_from = -1; en_to = -2;
    exp_addr = 32'h0; exp_if_data = 32'h0; exp_d_data = 64'h0;
    last_load = 64'h0123_4567_89AB_CDEF;
    for (int k = 0; k < n_cycles; k++) begin
      @(negedge clock);
      n_cmp++;
      if (if_ack !== (cyc == exp_if_at)) begin
        n_err++; $display("FAIL rnd_if_ack: cycle %0d got %b expected %b", cyc, if_ack, cyc == exp_if_at);
      end
      n_cmp++;
      if (d_ack !== (cyc == exp_d_at)) begin
        n_err++; $display("FAIL rnd_d_ack: cycle %0d got %b expected %b", cyc, d_ack, cyc == exp_d_at);
      end
      en_exp = (cyc >= en_from) && (cyc <= en_to);
      n_cmp++;
      if (mem_en !== en_exp) begin
        n_err++; $display("FAIL rnd_mem_en: cycle %0d got %b expected %b", cyc, mem_en, en_exp);
      end
      if (en_exp) begin
        n_cmp++;
        if (mem_addr !== exp_addr) begin
          n_err++; $display("FAIL rnd_mem_addr: cycle %0d got %h expected %h", cyc, mem_addr, exp_addr);
        end
      end
      if_drop = 1'b0; d_drop = 1'b0;
      if (cyc == exp_if_at) begin
        n_cmp++;
        if (if_rdata !== exp_if_data) begin
          n_err++; $display("FAIL rnd_if_rdata: cycle %0d got %h expected %h", cyc, if_rdata, exp_if_data);
        end
        if_req = 1'b0; if_drop = 1'b1;
      end
      if (cyc == exp_d_at) begin
        n_cmp++;
        if (d_rdata !== exp_d_data) begin
          n_err++; $display("FAIL rnd_d_rdata: cycle %0d got %h expected %h", cyc, d_rdata, exp_d_data);
        end
        d_req = 1'b0; d_drop = 1'b1;
      end
      // Inputs of an in-flight transaction may wander; the latched copy must be used.
      if (exp_d_at > cyc) begin d_addr = $urandom; d_wdata = {$urandom, $urandom}; d_we = 1'($urandom); end
      if (exp_if_at > cyc) if_addr = $urandom;
      if (!d_req && !d_drop && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom); d_addr = $urandom; d_wdata = {$urandom, $urandom};
      end
      if (!if_req && !if_drop && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      // Reference arbitration for a bus that is free in this cycle.
      if (cyc >= free_at && (d_req || if_req)) begin
        if (d_req && !(if_req && streak == MAXS)) begin
          streak = if_req ? streak + 1 : 0;
          exp_d_at = cyc + WS + 2;
          exp_addr = {d_addr[31:3], 3'b000};
          if (d_we) begin
            ref_mem[d_addr[10:3]] = d_wdata; ref_wr[d_addr[10:3]] = 1'b1;
            exp_d_data = last_load;
          end else begin
            exp_d_data = ref_read(d_addr[10:3]);
            last_load = exp_d_data;
          end
        end else begin
          streak = 0;
          exp_if_at = cyc + WS + 2;
          exp_addr = {if_addr[31:3], 3'b000};
          tmp = ref_read(if_addr[10:3]);
          exp_if_data = if_addr[2] ? tmp[63:32] : tmp[31:0];
        end
        en_from = cyc + 1; en_to = cyc + 1 + WS; free_at = cyc + WS + 3;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 64'h0;
    w0_d_req = 1'b0; w0_d_addr = 32'h0;
    probe_en = 1'b0; probe_val = 64'h0;
    test_reset();
    test_fetch_only();
    test_store_load();
    test_simultaneous();
    test_starvation();
    test_reset_mid_store();
    test_zero_wait();
    test_random(3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
